pbit_anneal_sampler: RTL and testbench

Parametrised annealing controller and result sampler for WIDTH-bit invertible p-bit adder cores.
- Accepts a job via a start pulse, holds the core in reset for one cycle, then ramps core bias I_0 from I_min to I_max.
- Waits a burn-in period, then counts per-bit 1-occupancy of a/b/sum/overflow over n_samples cycles.
- Emits majority-voted results with a done pulse. Replaces bench-side averaging.

---
 rtl/pbit_anneal_sampler_if.sv | 26 ++
 rtl/pbit_anneal_sampler.sv | 193 +++++++++++++++++++
 tb/tb_pbit_anneal_sampler.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/pbit_anneal_sampler_if.sv
// Controller <-> p-bit adder core bus: clamped operands and bias out, live p-bit states back.
interface pbit_anneal_sampler_if #(
  parameter int WIDTH   = 4,
  parameter int I_WIDTH = 4
);
  logic               core_reset;
  logic [1:0]         core_mode;
  logic [WIDTH-1:0]   core_a;
  logic [WIDTH-1:0]   core_b;
  logic [WIDTH-1:0]   core_sum;
  logic [I_WIDTH-1:0] I_0;
  logic [WIDTH-1:0]   core_a_out;
  logic [WIDTH-1:0]   core_b_out;
  logic [WIDTH-1:0]   core_sum_out;
  logic               core_ovf;

  modport master (
    output core_reset, core_mode, core_a, core_b, core_sum, I_0,
    input  core_a_out, core_b_out, core_sum_out, core_ovf
  );

  modport slave (
    input  core_reset, core_mode, core_a, core_b, core_sum, I_0,
    output core_a_out, core_b_out, core_sum_out, core_ovf
  );
endinterface

// File: rtl/pbit_anneal_sampler.sv
// Annealing controller for a p-bit adder core: bias ramp, burn-in, occupancy
// sampling and strict-majority result decision.
module pbit_anneal_sampler #(
  parameter int WIDTH     = 4,
  parameter int I_WIDTH   = 4,
  parameter int CNT_WIDTH = 10,
  parameter int TAU_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  input  logic [WIDTH-1:0]     sum_in,
  input  logic [TAU_WIDTH-1:0] log_tau,
  input  logic [I_WIDTH-1:0]   I_min,
  input  logic [I_WIDTH-1:0]   I_max,
  input  logic [CNT_WIDTH-1:0] burn_in,
  input  logic [CNT_WIDTH-1:0] n_samples,
  pbit_anneal_sampler_if.master core,
  output logic [WIDTH-1:0]     a_res,
  output logic [WIDTH-1:0]     b_res,
  output logic [WIDTH-1:0]     sum_res,
  output logic                 ovf_res,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int STEP_W     = (1 << TAU_WIDTH) - 1;
  localparam int STEP_LEN_W = STEP_W + 1;
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = 1;
  localparam logic [I_WIDTH-1:0]    I_ONE    = 1;
  localparam logic [STEP_LEN_W-1:0] STEP_ONE = 1;

  typedef enum logic [2:0] {IDLE, CLEAR, ANNEAL, BURN, SAMPLE, DECIDE} state_t;

  state_t state, state_nxt, after_ramp;

  logic [1:0]           mode_q;
  logic [WIDTH-1:0]     a_q, b_q, sum_q;
  logic [TAU_WIDTH-1:0] tau_q;
  logic [I_WIDTH-1:0]   imin_q, imax_q, i0_q, i0_inc;
  logic [CNT_WIDTH-1:0] burn_q, n_q, phase_cnt;
  logic [STEP_W-1:0]    step_cnt;
  logic [STEP_LEN_W-1:0] step_len;
  logic                 step_end, bad_q, cfg_bad, core_reset_c;

  logic [CNT_WIDTH-1:0] occ_a   [WIDTH];
  logic [CNT_WIDTH-1:0] occ_b   [WIDTH];
  logic [CNT_WIDTH-1:0] occ_sum [WIDTH];
  logic [CNT_WIDTH-1:0] occ_ovf;

  function automatic logic majority(input logic [CNT_WIDTH-1:0] cnt,
                                    input logic [CNT_WIDTH-1:0] n);
    return {cnt, 1'b0} > {1'b0, n};
  endfunction

  assign cfg_bad    = (mode == 2'd3) || (n_samples == '0) || (I_min > I_max);
  assign i0_inc     = i0_q + I_ONE;
  // One bias step lasts 2^log_tau cycles; step_cnt runs 0 .. 2^log_tau-1.
  assign step_len   = STEP_ONE << tau_q;
  assign step_end   = ({1'b0, step_cnt} == (step_len - STEP_ONE));
  assign after_ramp = (burn_q != '0) ? BURN : SAMPLE;

  assign core.core_reset = core_reset_c;
  assign core.core_mode  = mode_q;
  assign core.core_a     = a_q;
  assign core.core_b     = b_q;
  assign core.core_sum   = sum_q;
  assign core.I_0        = i0_q;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start) state_nxt = cfg_bad ? DECIDE : CLEAR;
      CLEAR:  state_nxt = (imin_q == imax_q) ? after_ramp : ANNEAL;
      ANNEAL: if (step_end && (i0_inc == imax_q)) state_nxt = after_ramp;
      BURN:   if (phase_cnt == burn_q - CNT_ONE) state_nxt = SAMPLE;
      SAMPLE: if (phase_cnt == n_q - CNT_ONE) state_nxt = DECIDE;
      DECIDE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy         = 1'b1;
    core_reset_c = 1'b0;
    case (state)
      IDLE: begin
        busy         = 1'b0;
        core_reset_c = 1'b1;
      end
      CLEAR, DECIDE: core_reset_c = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      tau_q     <= '0;
      imin_q    <= '0;
      imax_q    <= '0;
      burn_q    <= '0;
      n_q       <= '0;
      bad_q     <= 1'b0;
      i0_q      <= '0;
      step_cnt  <= '0;
      phase_cnt <= '0;
      occ_ovf   <= '0;
      a_res     <= '0;
      b_res     <= '0;
      sum_res   <= '0;
      ovf_res   <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        occ_a[i]   <= '0;
        occ_b[i]   <= '0;
        occ_sum[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          mode_q  <= mode;
          a_q     <= a_in;
          b_q     <= b_in;
          sum_q   <= sum_in;
          tau_q   <= log_tau;
          imin_q  <= I_min;
          imax_q  <= I_max;
          burn_q  <= burn_in;
          n_q     <= n_samples;
          bad_q   <= cfg_bad;
          err     <= 1'b0;
          occ_ovf <= '0;
          for (int unsigned i = 0; i < WIDTH; i++) begin
            occ_a[i]   <= '0;
            occ_b[i]   <= '0;
            occ_sum[i] <= '0;
          end
        end
        CLEAR: begin
          i0_q      <= imin_q;
          step_cnt  <= '0;
          phase_cnt <= '0;
        end
        ANNEAL: begin
          if (step_end) begin
            step_cnt <= '0;
            i0_q     <= i0_inc;
          end else begin
            step_cnt <= step_cnt + 1'b1;
          end
        end
        // phase_cnt is shared by BURN and SAMPLE, so it restarts on the hand-over.
        BURN: phase_cnt <= (state_nxt == BURN) ? phase_cnt + CNT_ONE : '0;
        SAMPLE: begin
          phase_cnt <= phase_cnt + CNT_ONE;
          if (core.core_ovf) occ_ovf <= occ_ovf + CNT_ONE;
          for (int unsigned i = 0; i < WIDTH; i++) begin
            if (core.core_a_out[i])   occ_a[i]   <= occ_a[i] + CNT_ONE;
            if (core.core_b_out[i])   occ_b[i]   <= occ_b[i] + CNT_ONE;
            if (core.core_sum_out[i]) occ_sum[i] <= occ_sum[i] + CNT_ONE;
          end
        end
        DECIDE: begin
          done    <= 1'b1;
          err     <= bad_q;
          ovf_res <= !bad_q && majority(occ_ovf, n_q);
          for (int unsigned i = 0; i < WIDTH; i++) begin
            a_res[i]   <= !bad_q && majority(occ_a[i], n_q);
            b_res[i]   <= !bad_q && majority(occ_b[i], n_q);
            sum_res[i] <= !bad_q && majority(occ_sum[i], n_q);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pbit_anneal_sampler.sv
// Directed bench for pbit_anneal_sampler: a job-level timing/occupancy model checked
// every cycle, plus hand-computed latencies, bias trace and results per job.
module tb_pbit_anneal_sampler;
  localparam int WIDTH = 4, I_WIDTH = 4, CNT_WIDTH = 10, TAU_WIDTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset, start;
  logic [1:0]           mode;
  logic [WIDTH-1:0]     a_in, b_in, sum_in;
  logic [TAU_WIDTH-1:0] log_tau;
  logic [I_WIDTH-1:0]   I_min, I_max;
  logic [CNT_WIDTH-1:0] burn_in, n_samples;
  logic [WIDTH-1:0]     a_res, b_res, sum_res;
  logic                 ovf_res, busy, done, err;

  pbit_anneal_sampler_if #(.WIDTH(WIDTH), .I_WIDTH(I_WIDTH)) core_bus ();

  pbit_anneal_sampler #(
    .WIDTH(WIDTH), .I_WIDTH(I_WIDTH), .CNT_WIDTH(CNT_WIDTH), .TAU_WIDTH(TAU_WIDTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .a_in(a_in), .b_in(b_in), .sum_in(sum_in), .log_tau(log_tau),
    .I_min(I_min), .I_max(I_max), .burn_in(burn_in), .n_samples(n_samples),
    .core(core_bus),
    .a_res(a_res), .b_res(b_res), .sum_res(sum_res), .ovf_res(ovf_res),
    .busy(busy), .done(done), .err(err)
  );

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Job-level model: one accepted job, its latency L and its sample window.
  bit   job = 0, bad = 0, finalized = 0;
  int   e = 0, L = 0, n = 0, tau = 0, imin = 0, imax = 0;
  int   i0_prev = 0, i0_hold = 0;
  int   cnt_a[WIDTH], cnt_b[WIDTH], cnt_s[WIDTH], cnt_o;
  logic [1:0] m_mode = '0;
  logic [WIDTH-1:0] m_a = '0, m_b = '0, m_s = '0, r_a = '0, r_b = '0, r_s = '0;
  logic r_o = 1'b0, r_err = 1'b0;
  int   t, tn, st, x_i0;
  bit   x_busy, x_done, x_crst;

  always @(negedge clk) begin
    t = cyc - e;
    if (job && t == L && !finalized) begin
      finalized = 1;
      r_err = bad;
      for (int i = 0; i < WIDTH; i++) begin
        r_a[i] = !bad && (2 * cnt_a[i] > n);
        r_b[i] = !bad && (2 * cnt_b[i] > n);
        r_s[i] = !bad && (2 * cnt_s[i] > n);
      end
      r_o = !bad && (2 * cnt_o > n);
    end
    x_busy = job && t < L;
    x_done = job && t == L;
    x_crst = !(job && !bad && t >= 1 && t <= L - 2);
    if (!job) x_i0 = i0_hold;
    else if (bad || t < 1) x_i0 = i0_prev;
    else begin
      st = (t - 1) >> tau;
      if (st > imax - imin) st = imax - imin;
      x_i0 = imin + st;
    end
    if (cyc >= 1) begin
      chk("busy", busy, x_busy);
      chk("done", done, x_done);
      chk("core_reset", core_bus.core_reset, x_crst);
      chk("I_0", core_bus.I_0, x_i0);
      chk("core_mode", core_bus.core_mode, m_mode);
      chk("core_a", core_bus.core_a, m_a);
      chk("core_b", core_bus.core_b, m_b);
      chk("core_sum", core_bus.core_sum, m_s);
      chk("a_res", a_res, r_a);
      chk("b_res", b_res, r_b);
      chk("sum_res", sum_res, r_s);
      chk("ovf_res", ovf_res, r_o);
      chk("err", err, r_err);
    end
    // Inputs now stable are what the next rising edge samples.
    if (!reset) begin
      job = 0; i0_hold = 0; r_err = 0; r_o = 0;
      r_a = '0; r_b = '0; r_s = '0;
      m_mode = '0; m_a = '0; m_b = '0; m_s = '0;
    end else begin
      tn = cyc + 1 - e;
      if (job && !bad && tn >= L - n && tn <= L - 1) begin
        for (int i = 0; i < WIDTH; i++) begin
          cnt_a[i] += int'(core_bus.core_a_out[i]);
          cnt_b[i] += int'(core_bus.core_b_out[i]);
          cnt_s[i] += int'(core_bus.core_sum_out[i]);
        end
        cnt_o += int'(core_bus.core_ovf);
      end
      if (start && !x_busy) begin
        i0_prev = x_i0;
        job = 1; finalized = 0; e = cyc + 1; r_err = 0;
        m_mode = mode; m_a = a_in; m_b = b_in; m_s = sum_in;
        tau = log_tau; imin = I_min; imax = I_max; n = n_samples;
        bad = (mode == 2'd3) || (n_samples == 0) || (I_min > I_max);
        L = bad ? 1 : 2 + ((imax - imin) << tau) + int'(burn_in) + n;
        for (int i = 0; i < WIDTH; i++) begin
          cnt_a[i] = 0; cnt_b[i] = 0; cnt_s[i] = 0;
        end
        cnt_o = 0;
      end
    end
  end

  int i0_trace[16];

  // L_lit = 0 means the job is expected never to complete (reset at rst_t).
  task automatic run_job(input string tag, input logic [1:0] md,
                         input logic [3:0] a, b, s, tau_v, imin_v, imax_v,
                         input int burn, nsmp, L_lit,
                         input logic [3:0] ca, cb, cs, input logic co,
                         input int pat_len, input logic [7:0] pat,
                         input int inj_t, rst_t,
                         input logic [3:0] xa, xb, xs, input logic xo, xerr,
                         input logic [3:0] xi0);
    int done_t, done_n, last, j;
    done_t = -1; done_n = 0;
    @(posedge clk); #2;
    start = 1; mode = md; a_in = a; b_in = b; sum_in = s; log_tau = tau_v;
    I_min = imin_v; I_max = imax_v; burn_in = 10'(burn); n_samples = 10'(nsmp);
    @(posedge clk); #2;
    start = 0; mode = 2'd3; a_in = ~a; b_in = ~b; sum_in = ~s;
    log_tau = 4'd9; I_min = 4'd15; I_max = 4'd0; burn_in = '0; n_samples = '0;
    last = (L_lit > 0) ? L_lit + 3 : 40;
    for (int k = 1; k <= last; k++) begin
      if (L_lit > 0 && k >= L_lit - nsmp && k <= L_lit - 1) begin
        core_bus.core_a_out = ca; core_bus.core_b_out = cb;
        core_bus.core_sum_out = cs; core_bus.core_ovf = co;
        j = k - (L_lit - nsmp);
        if (pat_len > 0 && j < 8) core_bus.core_sum_out[0] = pat[j];
      end else begin
        core_bus.core_a_out = ~ca; core_bus.core_b_out = ~cb;
        core_bus.core_sum_out = ~cs; core_bus.core_ovf = ~co;
      end
      start = (k == inj_t);
      reset = (k != rst_t);
      @(posedge clk); #2;
      if (done) begin
        done_n++;
        if (done_t < 0) done_t = k;
      end
      if (k < 16) i0_trace[k] = core_bus.I_0;
      if (k == rst_t) begin
        chk({tag, "_rst_busy"}, busy, 0);
        chk({tag, "_rst_I_0"}, core_bus.I_0, 0);
        chk({tag, "_rst_core_reset"}, core_bus.core_reset, 1);
      end
    end
    start = 0; reset = 1;
    chk({tag, "_latency"}, done_t, (L_lit > 0) ? L_lit : -1);
    chk({tag, "_done_count"}, done_n, (L_lit > 0) ? 1 : 0);
    chk({tag, "_a_res"}, a_res, xa);
    chk({tag, "_b_res"}, b_res, xb);
    chk({tag, "_sum_res"}, sum_res, xs);
    chk({tag, "_ovf_res"}, ovf_res, xo);
    chk({tag, "_err"}, err, xerr);
    chk({tag, "_I_0"}, core_bus.I_0, xi0);
  endtask

  initial begin
    int exp_ramp[7];
    exp_ramp = '{2, 2, 3, 3, 4, 4, 5};
    reset = 0; start = 0; mode = '0; a_in = '0; b_in = '0; sum_in = '0;
    log_tau = '0; I_min = '0; I_max = '0; burn_in = '0; n_samples = '0;
    core_bus.core_a_out = '0; core_bus.core_b_out = '0;
    core_bus.core_sum_out = '0; core_bus.core_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("reset_I_0", core_bus.I_0, 0);
    chk("reset_core_reset", core_bus.core_reset, 1);
    chk("reset_sum_res", sum_res, 0);

    run_job("fwd", 2'd0, 4'd1, 4'd7, 4'd0, 4'd2, 4'd2, 4'd15, 8, 101, 163,
            4'd1, 4'd7, 4'd8, 1'b0, 0, 8'h00, 0, 0, 4'd1, 4'd7, 4'd8, 1'b0, 1'b0, 4'd15);

    run_job("ramp", 2'd0, 4'd2, 4'd3, 4'd5, 4'd1, 4'd2, 4'd5, 0, 1, 9,
            4'd2, 4'd3, 4'd5, 1'b0, 0, 8'h00, 0, 0, 4'd2, 4'd3, 4'd5, 1'b0, 1'b0, 4'd5);
    for (int k = 1; k <= 7; k++) chk("ramp_trace", i0_trace[k], exp_ramp[k-1]);

    run_job("maj_tie", 2'd0, 4'd5, 4'd10, 4'd0, 4'd0, 4'd1, 4'd1, 0, 4, 6,
            4'd5, 4'd10, 4'b0110, 1'b1, 4, 8'h05, 0, 0, 4'd5, 4'd10, 4'd6, 1'b1, 1'b0, 4'd1);
    run_job("maj_win", 2'd0, 4'd5, 4'd10, 4'd0, 4'd0, 4'd1, 4'd1, 0, 4, 6,
            4'd5, 4'd10, 4'b0110, 1'b1, 4, 8'h0B, 0, 0, 4'd5, 4'd10, 4'd7, 1'b1, 1'b0, 4'd1);

    run_job("sub", 2'd2, 4'd3, 4'd0, 4'd12, 4'd0, 4'd0, 4'd3, 2, 5, 12,
            4'd3, 4'd9, 4'd12, 1'b0, 0, 8'h00, 9, 0, 4'd3, 4'd9, 4'd12, 1'b0, 1'b0, 4'd3);
    chk("sub_core_mode", core_bus.core_mode, 2);
    chk("sub_core_a", core_bus.core_a, 3);
    chk("sub_core_sum", core_bus.core_sum, 12);

    run_job("err_n0", 2'd0, 4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd1, 0, 0, 1,
            4'd15, 4'd15, 4'd15, 1'b1, 0, 8'h00, 0, 0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd3);
    run_job("err_mode3", 2'd3, 4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd1, 0, 4, 1,
            4'd15, 4'd15, 4'd15, 1'b1, 0, 8'h00, 0, 0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd3);
    run_job("err_range", 2'd0, 4'd1, 4'd1, 4'd1, 4'd0, 4'd9, 4'd3, 0, 4, 1,
            4'd15, 4'd15, 4'd15, 1'b1, 0, 8'h00, 0, 0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd3);

    run_job("abort", 2'd0, 4'd1, 4'd2, 4'd3, 4'd1, 4'd0, 4'd2, 1, 20, 0,
            4'd15, 4'd15, 4'd15, 1'b1, 0, 8'h00, 0, 12, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0);
    run_job("fresh", 2'd0, 4'd6, 4'd9, 4'd15, 4'd1, 4'd0, 4'd2, 1, 20, 27,
            4'd6, 4'd9, 4'd15, 1'b1, 0, 8'h00, 0, 0, 4'd6, 4'd9, 4'd15, 1'b1, 1'b0, 4'd2);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
